// File: rtl/uart_tx_fifo_if.sv
// Byte-write handshake and serial line of the FIFO-buffered UART transmitter.
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_busy;
  logic       tx_empty;
  logic       uart_txd;

  modport master (
    output tx_data,
    output tx_wr,
    input  tx_busy,
    input  tx_empty,
    input  uart_txd
  );

  modport slave (
    input  tx_data,
    input  tx_wr,
    output tx_busy,
    output tx_empty,
    output uart_txd
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a 4-entry byte FIFO; DIVISOR clocks per bit,
// back-to-back frames with no idle gap while bytes are queued.
module uart_tx_fifo #(
  parameter int unsigned DIVISOR = 434
) (
  input logic           clk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  localparam logic [15:0] BaudLast = 16'(DIVISOR - 1);

  state_e      state_q, state_d;
  logic [7:0]  mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        full, push, pop, baud_done;

  // Fullness comes from the registered count only, so a pop never frees a slot
  // for a write on the same edge.
  assign full      = (count_q == 3'd4);
  assign push      = bus.tx_wr && !full;
  assign baud_done = (baud_q == BaudLast);

  assign bus.tx_busy  = full;
  assign bus.tx_empty = (count_q == 3'd0) && (state_q == StIdle);
  assign bus.uart_txd = txd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    baud_d    = baud_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    unique case (state_q)
      StIdle: begin
        baud_d = 16'd0;
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_done) begin
          baud_d    = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end
      end
      StData: begin
        if (baud_done) begin
          baud_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (baud_done) begin
          baud_d = 16'd0;
          // Chain straight into the next start bit when more bytes are queued.
          if (count_q != 3'd0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is computed from the next state so the flopped output lines up
  // with the state it belongs to.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[bit_idx_d];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      baud_q    <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      txd_q     <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.tx_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo at DIVISOR=4: a line monitor decodes
// every frame cycle by cycle against a queue of expected bytes.
module tb_uart_tx_fifo;

  localparam int D = 4;
  localparam int FRAME = 10 * D;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  uart_tx_fifo_if u_if ();

  uart_tx_fifo #(.DIVISOR(D)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  int       vectors = 0;
  int       miscompares = 0;
  logic [7:0] sb[$];
  int       starts[$];
  int       cyc = 0;
  int       nframes = 0;
  bit       mon_busy = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    u_if.tx_data = b;
    u_if.tx_wr   = 1'b1;
    tick();
    u_if.tx_wr   = 1'b0;
  endtask

  // Samples the line on every falling edge and checks each cycle of each frame.
  task automatic monitor();
    logic [9:0] fr;
    int k;
    fr = '1;
    k  = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
        mon_busy = 1'b0;
        sb.delete();
        continue;
      end
      if (!mon_busy && u_if.uart_txd === 1'b0) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, none required", cyc);
          fr = 10'h200;
        end else begin
          fr = {1'b1, sb.pop_front(), 1'b0};
        end
        mon_busy = 1'b1;
        k = 0;
        starts.push_back(cyc);
        nframes++;
      end
      if (mon_busy) begin
        vectors++;
        if (u_if.uart_txd !== fr[k / D]) begin
          miscompares++;
          $display("FAIL line_bit: frame %h bit %0d clk %0d got %b want %b",
                   fr[8:1], k / D, k % D, u_if.uart_txd, fr[k / D]);
        end
        k++;
        if (k == FRAME) mon_busy = 1'b0;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (u_if.tx_empty === 1'b1 && !mon_busy && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL drain_timeout: still busy after %0d cycles, idle required", budget);
    end
    tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors += 3;
    if (u_if.uart_txd !== 1'b1) begin
      miscompares++; $display("FAIL reset_txd: got %b want 1", u_if.uart_txd);
    end
    if (u_if.tx_busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b want 0", u_if.tx_busy);
    end
    if (u_if.tx_empty !== 1'b1) begin
      miscompares++; $display("FAIL reset_empty: got %b want 1", u_if.tx_empty);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    // First edge after release must accept a write.
    sb.push_back(8'h5A);
    write_byte(8'h5A);
    vectors++;
    if (u_if.tx_empty !== 1'b0) begin
      miscompares++; $display("FAIL first_edge_write: tx_empty got %b want 0", u_if.tx_empty);
    end
    wait_drain(100);
  endtask

  task automatic test_single();
    starts.delete();
    sb.push_back(8'hA5);
    write_byte(8'hA5);
    vectors += 2;
    if (u_if.uart_txd !== 1'b1) begin
      miscompares++; $display("FAIL latency_e0: txd got %b want 1", u_if.uart_txd);
    end
    if (u_if.tx_empty !== 1'b0) begin
      miscompares++; $display("FAIL empty_after_write: got %b want 0", u_if.tx_empty);
    end
    tick();
    vectors++;
    if (u_if.uart_txd !== 1'b0) begin
      miscompares++; $display("FAIL latency_e1: txd got %b want 0", u_if.uart_txd);
    end
    repeat (39) tick();
    vectors++;
    if (u_if.tx_empty !== 1'b0) begin
      miscompares++; $display("FAIL empty_at_e40: got %b want 0", u_if.tx_empty);
    end
    tick();
    vectors++;
    if (u_if.tx_empty !== 1'b1) begin
      miscompares++; $display("FAIL empty_at_e41: got %b want 1", u_if.tx_empty);
    end
    wait_drain(20);
  endtask

  task automatic test_extremes();
    logic [7:0] vals [2];
    int want_low [2];
    vals[0] = 8'h00; want_low[0] = 36;
    vals[1] = 8'hFF; want_low[1] = 4;
    for (int v = 0; v < 2; v++) begin
      int lows;
      lows = 0;
      sb.push_back(vals[v]);
      write_byte(vals[v]);
      for (int i = 0; i < 45; i++) begin
        tick();
        if (u_if.uart_txd === 1'b0) lows++;
      end
      vectors++;
      if (lows !== want_low[v]) begin
        miscompares++;
        $display("FAIL low_count_%h: got %0d want %0d", vals[v], lows, want_low[v]);
      end
      wait_drain(20);
    end
  endtask

  task automatic test_back_to_back();
    starts.delete();
    for (int n = 0; n < 6; n++) begin
      if (n < 5) sb.push_back(8'(n + 1));
      u_if.tx_data = 8'(n + 1);
      u_if.tx_wr   = 1'b1;
      tick();
      vectors++;
      if (u_if.tx_busy !== (n >= 4)) begin
        miscompares++;
        $display("FAIL b2b_busy_w%0d: got %b want %b", n + 1, u_if.tx_busy, n >= 4);
      end
    end
    u_if.tx_wr = 1'b0;
    wait_drain(300);
    vectors++;
    if (starts.size() != 5) begin
      miscompares++; $display("FAIL b2b_frames: got %0d want 5", starts.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        vectors++;
        if (starts[i] - starts[i-1] != FRAME) begin
          miscompares++;
          $display("FAIL b2b_gap_%0d: got %0d want %0d", i, starts[i] - starts[i-1], FRAME);
        end
      end
      vectors++;
      if (starts[4] + FRAME - starts[0] != 200) begin
        miscompares++;
        $display("FAIL b2b_span: got %0d want 200", starts[4] + FRAME - starts[0]);
      end
    end
  endtask

  // Second write lands on the last STOP edge (e40) or one edge later (e41).
  task automatic test_stop_edge();
    for (int v = 0; v < 2; v++) begin
      starts.delete();
      sb.push_back(8'h3C);
      write_byte(8'h3C);
      repeat (39 + v) tick();
      sb.push_back(8'hC3);
      write_byte(8'hC3);
      wait_drain(120);
      vectors++;
      if (starts.size() != 2) begin
        miscompares++; $display("FAIL stop_edge_frames_%0d: got %0d want 2", v, starts.size());
      end else if (starts[1] - starts[0] != FRAME + v) begin
        miscompares++;
        $display("FAIL stop_edge_gap_%0d: got %0d want %0d", v, starts[1] - starts[0], FRAME + v);
      end
    end
  endtask

  task automatic test_full_hold();
    starts.delete();
    for (int n = 0; n < 100; n++) begin
      logic want_busy;
      u_if.tx_data = (n < 6) ? 8'(n + 1) : 8'h80 + 8'(n);
      u_if.tx_wr   = 1'b1;
      if (n < 5) sb.push_back(8'(n + 1));
      // Slots free at the pops on e41 and e81; the very next edge refills them.
      if (n == 42 || n == 82) sb.push_back(8'h80 + 8'(n));
      tick();
      want_busy = (n >= 4) && (n != 41) && (n != 81);
      vectors++;
      if (u_if.tx_busy !== want_busy) begin
        miscompares++;
        $display("FAIL full_busy_e%0d: got %b want %b", n, u_if.tx_busy, want_busy);
      end
    end
    u_if.tx_wr = 1'b0;
    wait_drain(400);
    vectors++;
    if (starts.size() != 7) begin
      miscompares++; $display("FAIL full_frames: got %0d want 7", starts.size());
    end else begin
      for (int i = 1; i < 7; i++) begin
        vectors++;
        if (starts[i] - starts[i-1] != FRAME) begin
          miscompares++;
          $display("FAIL full_gap_%0d: got %0d want %0d", i, starts[i] - starts[i-1], FRAME);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int nf;
    sb.push_back(8'h37);
    write_byte(8'h37);
    repeat (18) tick();
    vectors++;
    if (u_if.uart_txd !== 1'b0) begin
      miscompares++; $display("FAIL mid_bit3_low: got %b want 0", u_if.uart_txd);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors += 3;
    if (u_if.uart_txd !== 1'b1) begin
      miscompares++; $display("FAIL mid_reset_txd: got %b want 1", u_if.uart_txd);
    end
    if (u_if.tx_empty !== 1'b1) begin
      miscompares++; $display("FAIL mid_reset_empty: got %b want 1", u_if.tx_empty);
    end
    if (u_if.tx_busy !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset_busy: got %b want 0", u_if.tx_busy);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    nf = nframes;
    repeat (100) tick();
    vectors += 2;
    if (nframes != nf) begin
      miscompares++; $display("FAIL post_reset_frames: got %0d want %0d", nframes, nf);
    end
    if (u_if.uart_txd !== 1'b1) begin
      miscompares++; $display("FAIL post_reset_line: got %b want 1", u_if.uart_txd);
    end
  endtask

  initial begin
    u_if.tx_data = 8'h00;
    u_if.tx_wr   = 1'b0;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, completion required");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_single();
    test_extremes();
    test_back_to_back();
    test_stop_edge();
    test_full_hold();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
